// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame receiver: status codes, frame FSM states
// and the MSB-first CRC8 step function.
package uart_frame_pkg;

    localparam logic [7:0] ST_OK      = 8'h01;
    localparam logic [7:0] ST_TAIL    = 8'h02;
    localparam logic [7:0] ST_FRAME   = 8'h03;
    localparam logic [7:0] ST_CRC     = 8'h04;
    localparam logic [7:0] ST_TIMEOUT = 8'h05;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CRC,
        S_TAIL
    } frx_state_e;

    // Non-reflected CRC8 with no final XOR: the byte is folded in first,
    // then eight shift/XOR steps.
    function automatic logic [7:0] crc8(input logic [7:0] crc,
                                        input logic [7:0] data,
                                        input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, false-start rejection, mid-bit sampling
// and a stop-bit check that yields either byte_valid or byte_err.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BPS_CNT - 1);

    logic             rxd_s1, rxd_s2, rxd_d;
    logic             rx_on;
    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_p0;
    logic             start_edge;

    assign start_edge = rxd_d & ~rxd_s2;

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            rxd_s1     <= 1'b1;
            rxd_s2     <= 1'b1;
            rxd_d      <= 1'b1;
            rx_on      <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_p0   <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rxd_s1     <= uart_rxd;
            rxd_s2     <= rxd_s1;
            rxd_d      <= rxd_s2;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (!rx_on) begin
                if (start_edge) begin
                    rx_on   <= 1'b1;
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else begin
                clk_cnt <= (clk_cnt == CNT_END) ? '0 : clk_cnt + 1'b1;
                if (clk_cnt == CNT_END)
                    bit_cnt <= bit_cnt + 4'd1;
                // Mid-bit sample; leaving rx_on at the stop sample re-arms half a bit early.
                if (clk_cnt == CNT_MID) begin
                    if (bit_cnt == 4'd0) begin
                        if (rxd_s2)
                            rx_on <= 1'b0;
                    end else if (bit_cnt <= 4'd8) begin
                        shift_p0 <= {rxd_s2, shift_p0[7:1]};
                    end else begin
                        rx_on <= 1'b0;
                        if (rxd_s2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_p0;
                        end else begin
                            byte_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: HEAD | PAYLOAD_LEN bytes | CRC8 | TAIL, with status reporting.
// Optional inter-byte timeout enabled by defining UART_FRX_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         UART_BPS     = 115200,
    parameter int         PAYLOAD_LEN  = 11,
    parameter logic [7:0] HEAD_BYTE    = 8'h55,
    parameter logic [7:0] TAIL_BYTE    = 8'hAA,
    parameter logic [7:0] CRC_POLY     = 8'h07,
    parameter logic [7:0] CRC_INIT     = 8'h00,
    parameter int         TIMEOUT_BITS = 30
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     uart_rxd,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    output logic                     byte_err,
    output logic                     busy,
    output logic [8*PAYLOAD_LEN-1:0] payload,
    output logic                     frame_valid,
    output logic [7:0]               status,
    output logic                     status_valid
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int IDX_W   = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_err;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_byte_rx (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .byte_data  (rx_byte),
        .byte_valid (rx_vld),
        .byte_err   (rx_err)
    );

    assign byte_data  = rx_byte;
    assign byte_valid = rx_vld;
    assign byte_err   = rx_err;

    frx_state_e               state, state_nxt;
    logic [IDX_W-1:0]         idx;
    logic [7:0]               crc;
    logic                     crc_bad;
    logic [8*PAYLOAD_LEN-1:0] stage;
    logic                     timeout_hit;
    logic                     do_head, do_data, do_crc, do_ok, st_load;
    logic [7:0]               st_code;

    assign busy = (state != S_IDLE);

`ifdef UART_FRX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n || state == S_IDLE || rx_vld)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state != S_IDLE) && (to_cnt == TO_W'(TO_LIMIT - 1));
`else
    // Without the timeout a partial frame waits indefinitely; the parameters stay for a uniform interface.
    assign timeout_hit = (TIMEOUT_BITS * BPS_CNT < 0);
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // A byte beats a same-cycle timeout; a framing error mid-frame aborts it.
    always_comb begin
        state_nxt = state;
        do_head   = 1'b0;
        do_data   = 1'b0;
        do_crc    = 1'b0;
        do_ok     = 1'b0;
        st_load   = 1'b0;
        st_code   = ST_OK;
        if (rx_err && state != S_IDLE) begin
            st_load   = 1'b1;
            st_code   = ST_FRAME;
            state_nxt = S_IDLE;
        end else if (rx_vld) begin
            case (state)
                S_IDLE: begin
                    if (rx_byte == HEAD_BYTE) begin
                        do_head   = 1'b1;
                        state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    do_data = 1'b1;
                    if (idx == IDX_LAST)
                        state_nxt = S_CRC;
                end
                S_CRC: begin
                    do_crc    = 1'b1;
                    state_nxt = S_TAIL;
                end
                S_TAIL: begin
                    st_load   = 1'b1;
                    state_nxt = S_IDLE;
                    if (rx_byte != TAIL_BYTE)
                        st_code = ST_TAIL;
                    else if (crc_bad)
                        st_code = ST_CRC;
                    else
                        do_ok = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (timeout_hit) begin
            st_load   = 1'b1;
            st_code   = ST_TIMEOUT;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            idx          <= '0;
            crc          <= CRC_INIT;
            crc_bad      <= 1'b0;
            payload      <= '0;
            status       <= '0;
            frame_valid  <= 1'b0;
            status_valid <= 1'b0;
        end else begin
            frame_valid  <= do_ok;
            status_valid <= st_load;
            if (st_load)
                status <= st_code;
            if (do_head) begin
                idx     <= '0;
                crc     <= CRC_INIT;
                crc_bad <= 1'b0;
            end
            if (do_data) begin
                idx <= idx + 1'b1;
                crc <= crc8(crc, rx_byte, CRC_POLY);
            end
            if (do_crc)
                crc_bad <= (rx_byte != crc);
            if (do_ok)
                payload <= stage;
        end
    end

    // Staging buffer holds the frame under assembly; it needs no reset.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (do_data && idx == IDX_W'(i))
                stage[8*i +: 8] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: three instances (PAYLOAD_LEN 11, 1, 32) on separate lines.
module tb_uart_frame_rx;

    localparam int BPS = 16;
    localparam int TO_LIMIT = 30 * BPS;

    typedef struct {
        int           ln;
        logic [7:0]   st;
        logic [255:0] pl;
        bit           to;
    } ev_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b1;
    logic [2:0]   rxd = 3'b111;

    logic [7:0]   bd0, bd1, bd2, st0, st1, st2;
    logic         bv0, bv1, bv2, be0, be1, be2, busy0, busy1, busy2;
    logic         fv0, fv1, fv2, sv0, sv1, sv2;
    logic [87:0]  pl0;
    logic [7:0]   pl1;
    logic [255:0] pl2;

    ev_t          exp_q[$];
    logic [255:0] model_pl[3];
    int           n_cmp = 0, n_bad = 0;
    int           cyc = 0, last_bv_cyc = 0, bv_cnt = 0, be_cnt = 0, fv_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    uart_frame_rx #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .PAYLOAD_LEN(11)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[0]),
        .byte_data(bd0), .byte_valid(bv0), .byte_err(be0), .busy(busy0),
        .payload(pl0), .frame_valid(fv0), .status(st0), .status_valid(sv0));

    uart_frame_rx #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .PAYLOAD_LEN(1)) dut_len1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[1]),
        .byte_data(bd1), .byte_valid(bv1), .byte_err(be1), .busy(busy1),
        .payload(pl1), .frame_valid(fv1), .status(st1), .status_valid(sv1));

    uart_frame_rx #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .PAYLOAD_LEN(32)) dut_len32 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[2]),
        .byte_data(bd2), .byte_valid(bv2), .byte_err(be2), .busy(busy2),
        .payload(pl2), .frame_valid(fv2), .status(st2), .status_valid(sv2));

    function automatic logic [7:0] tb_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            fb = r[7] ^ d[k];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever any instance reports a status.
    always @(negedge sys_clk) begin
        logic [7:0]   g_st;
        logic         g_fv;
        logic [255:0] g_pl;
        ev_t          e;
        cyc++;
        if (bv0) begin bv_cnt++; last_bv_cyc = cyc; end
        if (be0) be_cnt++;
        if (fv0) fv_cnt++;
        for (int l = 0; l < 3; l++) begin
            if ((l == 0 && sv0) || (l == 1 && sv1) || (l == 2 && sv2)) begin
                g_st = (l == 0) ? st0 : (l == 1) ? st1 : st2;
                g_fv = (l == 0) ? fv0 : (l == 1) ? fv1 : fv2;
                g_pl = (l == 0) ? 256'(pl0) : (l == 1) ? 256'(pl1) : pl2;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_status line %0d: got %02h, required no status", l, g_st);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ln != l || g_st !== e.st) begin
                        n_bad++;
                        $display("FAIL status line %0d: got %02h, required %02h on line %0d", l, g_st, e.st, e.ln);
                    end
                    n_cmp++;
                    if (g_fv !== (e.st == 8'h01)) begin
                        n_bad++;
                        $display("FAIL frame_valid line %0d: got %b, required %b", l, g_fv, e.st == 8'h01);
                    end
                    n_cmp++;
                    if (g_pl !== e.pl) begin
                        n_bad++;
                        $display("FAIL payload line %0d: got %h, required %h", l, g_pl, e.pl);
                    end
                    if (e.to) begin
                        n_cmp++;
                        if (cyc - last_bv_cyc < TO_LIMIT || cyc - last_bv_cyc > TO_LIMIT + 2) begin
                            n_bad++;
                            $display("FAIL timeout_delay: got %0d cycles, required %0d..%0d", cyc - last_bv_cyc, TO_LIMIT, TO_LIMIT + 2);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge sys_clk);
        $display("FAIL watchdog: got no end of test, required finish within 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input int ln, input logic [7:0] b, input logic stop_bit);
        rxd[ln] = 1'b0;
        repeat (BPS) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rxd[ln] = b[i];
            repeat (BPS) @(negedge sys_clk);
        end
        rxd[ln] = stop_bit;
        repeat (BPS) @(negedge sys_clk);
        rxd[ln] = 1'b1;
    endtask

    // Expectation pushed up front; err_idx >= 0 sends that payload byte with a bad stop bit and aborts.
    task automatic send_frame(input int ln, input int len, input logic [7:0] base,
                              input logic [7:0] crc_xor, input logic [7:0] tail, input int err_idx);
        logic [7:0]   c, b, st;
        logic [255:0] pl;
        ev_t          e;
        c  = 8'h00;
        pl = '0;
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            pl[8*i +: 8] = b;
            c = tb_crc(c, b);
        end
        if (err_idx >= 0)        st = 8'h03;
        else if (tail != 8'hAA)  st = 8'h02;
        else if (crc_xor != 0)   st = 8'h04;
        else                     st = 8'h01;
        if (st == 8'h01) model_pl[ln] = pl;
        e.ln = ln; e.st = st; e.pl = model_pl[ln]; e.to = 1'b0;
        exp_q.push_back(e);
        send_byte(ln, 8'h55, 1'b1);
        for (int i = 0; i < len; i++) begin
            if (i == err_idx) begin
                send_byte(ln, pl[8*i +: 8], 1'b0);
                return;
            end
            send_byte(ln, pl[8*i +: 8], 1'b1);
        end
        send_byte(ln, c ^ crc_xor, 1'b1);
        send_byte(ln, tail, 1'b1);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        n_cmp++;
        if ({busy0, sv0, fv0, bv0, be0} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 00000", {busy0, sv0, fv0, bv0, be0});
        end
        n_cmp++;
        if (st0 !== 8'h00 || bd0 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_status_byte: got %02h/%02h, required 00/00", st0, bd0);
        end
        n_cmp++;
        if (pl0 !== 88'h0 || pl2 !== 256'h0) begin
            n_bad++;
            $display("FAIL reset_payload: got %h, required 0", pl0);
        end
    endtask

    task automatic test_good_frame();
        int fv0_start;
        fv0_start = fv_cnt;
        send_frame(0, 11, 8'h01, 8'h00, 8'hAA, -1);
        repeat (40) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL good_frame_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (fv_cnt - fv0_start != 1) begin
            n_bad++;
            $display("FAIL good_frame_fv_count: got %0d, required 1", fv_cnt - fv0_start);
        end
        n_cmp++;
        if (bd0 !== 8'hAA) begin
            n_bad++;
            $display("FAIL last_byte_data: got %02h, required aa", bd0);
        end
    endtask

    task automatic test_bad_crc();
        int fv0_start;
        fv0_start = fv_cnt;
        send_frame(0, 11, 8'h01, 8'hFF, 8'hAA, -1);
        repeat (40) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0 || fv_cnt != fv0_start) begin
            n_bad++;
            $display("FAIL bad_crc: got %0d outstanding / %0d frame_valid, required 0 / 0", exp_q.size(), fv_cnt - fv0_start);
            exp_q.delete();
        end
    endtask

    task automatic test_bad_tail_and_junk();
        send_frame(0, 11, 8'h30, 8'h00, 8'h5A, -1);
        send_byte(0, 8'h13, 1'b1);
        send_byte(0, 8'hFF, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        n_cmp++;
        if (busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL junk_busy: got %b, required 0", busy0);
        end
        send_frame(0, 11, 8'h20, 8'h00, 8'hAA, -1);
        repeat (40) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL tail_junk_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch_and_framing();
        int bv_start, be_start;
        bv_start = bv_cnt;
        be_start = be_cnt;
        rxd[0] = 1'b0;
        repeat (BPS / 4) @(negedge sys_clk);
        rxd[0] = 1'b1;
        repeat (3 * BPS) @(negedge sys_clk);
        n_cmp++;
        if (bv_cnt != bv_start || be_cnt != be_start || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch: got %0d byte_valid / %0d byte_err / busy %b, required 0 / 0 / 0",
                     bv_cnt - bv_start, be_cnt - be_start, busy0);
        end
        send_frame(0, 11, 8'h01, 8'h00, 8'hAA, 4);
        repeat (4 * BPS) @(negedge sys_clk);
        n_cmp++;
        if (be_cnt - be_start != 1 || busy0 !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL framing: got %0d byte_err / busy %b / %0d outstanding, required 1 / 0 / 0",
                     be_cnt - be_start, busy0, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout();
        ev_t e;
`ifdef UART_FRX_TIMEOUT_EN
        e.ln = 0; e.st = 8'h05; e.pl = model_pl[0]; e.to = 1'b1;
        exp_q.push_back(e);
        send_byte(0, 8'h55, 1'b1);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h02, 1'b1);
        repeat (31 * BPS) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: got %0d outstanding / busy %b, required 0 / 0", exp_q.size(), busy0);
            exp_q.delete();
        end
`else
        logic [7:0]   c;
        logic [255:0] pl;
        c  = 8'h00;
        pl = '0;
        for (int i = 0; i < 11; i++) begin
            pl[8*i +: 8] = 8'(i + 1);
            c = tb_crc(c, 8'(i + 1));
        end
        model_pl[0] = pl;
        e.ln = 0; e.st = 8'h01; e.pl = pl; e.to = 1'b0;
        exp_q.push_back(e);
        send_byte(0, 8'h55, 1'b1);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h02, 1'b1);
        repeat (31 * BPS) @(negedge sys_clk);
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL no_timeout_busy: got %b, required 1", busy0);
        end
        for (int i = 2; i < 11; i++) send_byte(0, pl[8*i +: 8], 1'b1);
        send_byte(0, c, 1'b1);
        send_byte(0, 8'hAA, 1'b1);
        repeat (40) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL resumed_frame_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
`endif
    endtask

    task automatic test_reset_mid();
        send_byte(0, 8'h55, 1'b1);
        for (int i = 1; i <= 4; i++) send_byte(0, 8'(i), 1'b1);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        for (int l = 0; l < 3; l++) model_pl[l] = '0;
        n_cmp++;
        if ({busy0, sv0, fv0} !== 3'b0 || st0 !== 8'h00 || pl0 !== 88'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy %b sv %b fv %b status %02h payload %h, required all 0",
                     busy0, sv0, fv0, st0, pl0);
        end
        send_frame(0, 11, 8'h40, 8'h00, 8'hAA, -1);
        repeat (40) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL after_reset_pending: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back_lengths();
        send_frame(1, 1, 8'h77, 8'h00, 8'hAA, -1);
        send_frame(1, 1, 8'h12, 8'h00, 8'hAA, -1);
        send_frame(2, 32, 8'h80, 8'h00, 8'hAA, -1);
        send_frame(2, 32, 8'hC3, 8'h00, 8'hAA, -1);
        repeat (40) @(negedge sys_clk);
        n_cmp++;
        if (exp_q.size() != 0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL lengths: got %0d outstanding / busy %b%b, required 0 / 00", exp_q.size(), busy1, busy2);
            exp_q.delete();
        end
    endtask

    initial begin
        for (int l = 0; l < 3; l++) model_pl[l] = '0;
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_bad_tail_and_junk();
        test_glitch_and_framing();
        test_timeout();
        test_reset_mid();
        test_back_to_back_lengths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
